// File: rtl/up_down_counter_driver_if.sv
// Command and counter-side signal bundle for up_down_counter_driver.
// The slave modport is the driver's view; the master modport is the command source plus counter.
interface up_down_counter_driver_if #(
   parameter int WIDTH = 16,
   parameter int LENW  = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [LENW-1:0]  cmd_len;
   logic [WIDTH-1:0] cmd_data;
   logic             count_enb;
   logic             updn_cnt;
   logic             ld_cnt;
   logic             cnt_rst;
   logic [WIDTH-1:0] load_data;
   logic [WIDTH-1:0] cnt_obs;
   logic [WIDTH-1:0] exp_cnt;
   logic             mismatch;
   logic             busy;

   modport slave (
      input  cmd_valid, cmd_op, cmd_len, cmd_data, cnt_obs,
      output cmd_ready, count_enb, updn_cnt, ld_cnt, cnt_rst, load_data,
             exp_cnt, mismatch, busy
   );

   modport master (
      output cmd_valid, cmd_op, cmd_len, cmd_data, cnt_obs,
      input  cmd_ready, count_enb, updn_cnt, ld_cnt, cnt_rst, load_data,
             exp_cnt, mismatch, busy
   );
endinterface

// File: rtl/up_down_counter_driver.sv
// Command-driven controller for an external up/down counter that also models the
// counter value and flags any divergence between the model and the observed count.
module up_down_counter_driver #(
   parameter int WIDTH = 16,
   parameter int LENW  = 8
) (
   input logic                    clk,
   input logic                    rst,
   up_down_counter_driver_if.slave bus
);

   typedef enum logic [2:0] {
      ST_RESET = 3'd0,
      ST_IDLE  = 3'd1,
      ST_LOAD  = 3'd2,
      ST_RUN   = 3'd3,
      ST_HOLD  = 3'd4
   } state_t;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_UP   = 2'b01;
   localparam logic [1:0] OP_DOWN = 2'b10;

   state_t           r_state;
   logic [LENW-1:0]  r_rem;
   logic             r_cnt_rst;
   logic             r_ld_cnt;
   logic             r_count_enb;
   logic             r_updn_cnt;
   logic [WIDTH-1:0] r_load_data;
   logic [WIDTH-1:0] r_exp_cnt;
   logic             r_mismatch;

   state_t           w_state_nxt;
   logic [LENW-1:0]  w_rem_nxt;
   logic             w_cnt_rst_nxt;
   logic             w_ld_cnt_nxt;
   logic             w_count_enb_nxt;
   logic             w_updn_nxt;
   logic [WIDTH-1:0] w_load_data_nxt;
   logic [WIDTH-1:0] w_exp_nxt;
   logic             w_mismatch_nxt;

   // Mirrors the counter's priority: reset, then load, then count (wrapping).
   function automatic logic [WIDTH-1:0] f_exp_next(
      input logic             crst_n,
      input logic             ld_n,
      input logic             enb,
      input logic             up,
      input logic [WIDTH-1:0] cur,
      input logic [WIDTH-1:0] ldd
   );
      logic [WIDTH-1:0] res;
      if (!crst_n) begin
         res = {WIDTH{1'b0}};
      end else if (!ld_n) begin
         res = ldd;
      end else if (enb) begin
         res = up ? (cur + WIDTH'(1)) : (cur - WIDTH'(1));
      end else begin
         res = cur;
      end
      return res;
   endfunction

   // Next-state and next-output decode for the command sequencer.
   always_comb begin
      w_state_nxt     = r_state;
      w_rem_nxt       = r_rem;
      w_cnt_rst_nxt   = 1'b1;
      w_ld_cnt_nxt    = 1'b1;
      w_count_enb_nxt = 1'b0;
      w_updn_nxt      = r_updn_cnt;
      w_load_data_nxt = r_load_data;
      case (r_state)
         ST_RESET: begin
            w_state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               case (bus.cmd_op)
                  OP_LOAD: begin
                     w_state_nxt     = ST_LOAD;
                     w_ld_cnt_nxt    = 1'b0;
                     w_load_data_nxt = bus.cmd_data;
                  end
                  OP_UP, OP_DOWN: begin
                     // A zero-length count degenerates into a one-cycle busy hold.
                     if (bus.cmd_len != LENW'(0)) begin
                        w_state_nxt     = ST_RUN;
                        w_rem_nxt       = bus.cmd_len - LENW'(1);
                        w_count_enb_nxt = 1'b1;
                        w_updn_nxt      = (bus.cmd_op == OP_UP);
                     end else begin
                        w_state_nxt = ST_HOLD;
                        w_rem_nxt   = LENW'(0);
                     end
                  end
                  default: begin
                     w_state_nxt = ST_HOLD;
                     if (bus.cmd_len != LENW'(0)) begin
                        w_rem_nxt = bus.cmd_len - LENW'(1);
                     end else begin
                        w_rem_nxt = LENW'(0);
                     end
                  end
               endcase
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_LOAD: begin
            w_state_nxt = ST_IDLE;
         end
         ST_RUN: begin
            if (r_rem == LENW'(0)) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_rem_nxt       = r_rem - LENW'(1);
               w_count_enb_nxt = 1'b1;
            end
         end
         ST_HOLD: begin
            if (r_rem == LENW'(0)) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_rem_nxt = r_rem - LENW'(1);
            end
         end
         default: begin
            w_state_nxt   = ST_RESET;
            w_cnt_rst_nxt = 1'b0;
         end
      endcase
   end

   // Model update and sticky compare, both based on values present before the edge.
   always_comb begin
      w_exp_nxt = f_exp_next(r_cnt_rst, r_ld_cnt, r_count_enb, r_updn_cnt,
                             r_exp_cnt, r_load_data);
      if ((r_state != ST_RESET) && (bus.cnt_obs != r_exp_cnt)) begin
         w_mismatch_nxt = 1'b1;
      end else begin
         w_mismatch_nxt = r_mismatch;
      end
   end

   // State and registered outputs; rst aborts any command at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_RESET;
         r_rem       <= LENW'(0);
         r_cnt_rst   <= 1'b0;
         r_ld_cnt    <= 1'b1;
         r_count_enb <= 1'b0;
         r_updn_cnt  <= 1'b0;
         r_load_data <= {WIDTH{1'b0}};
         r_exp_cnt   <= {WIDTH{1'b0}};
         r_mismatch  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_rem       <= w_rem_nxt;
         r_cnt_rst   <= w_cnt_rst_nxt;
         r_ld_cnt    <= w_ld_cnt_nxt;
         r_count_enb <= w_count_enb_nxt;
         r_updn_cnt  <= w_updn_nxt;
         r_load_data <= w_load_data_nxt;
         r_exp_cnt   <= w_exp_nxt;
         r_mismatch  <= w_mismatch_nxt;
      end
   end

   assign bus.cmd_ready = (r_state == ST_IDLE);
   assign bus.busy      = (r_state != ST_IDLE);
   assign bus.cnt_rst   = r_cnt_rst;
   assign bus.ld_cnt    = r_ld_cnt;
   assign bus.count_enb = r_count_enb;
   assign bus.updn_cnt  = r_updn_cnt;
   assign bus.load_data = r_load_data;
   assign bus.exp_cnt   = r_exp_cnt;
   assign bus.mismatch  = r_mismatch;

endmodule
